// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_ctrl_pkg
// Brief   : Shared definitions for the memory-controller front end:
//           rw encoding and the request-scheduler state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_RESP    = 2'd3
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_req_fifo.sv
`default_nettype none
// ============================================================================
// Module  : mem_req_fifo
// Brief   : DEPTH x W synchronous request FIFO. Head entry is read
//           combinationally from storage; push is refused when full even if
//           a pop happens on the same edge.
// Revision: 1.0 - initial release
// ============================================================================
module mem_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full
);
    import mem_ctrl_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level_q == LVL_FULL);
    assign push_ok = push && !full;
    assign pop_ok  = pop && (level_q != '0);
    assign head    = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Next storage, pointers (wrap naturally at DEPTH) and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // FIFO state registers; reset discards all contents
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_req_sched.sv
`default_nettype none
// ============================================================================
// Module  : mem_req_sched
// Brief   : Request scheduler in front of the R x C x N memory controller.
//           Queues host requests, issues them in order one at a time, waits
//           for read data (with timeout) and returns it on a valid/ready
//           response channel.
// Revision: 1.0 - initial release
// ============================================================================
module mem_req_sched #(
    parameter int R     = 4,
    parameter int C     = 4,
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int TMO   = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_rw,
    input  logic [$clog2(R*C)-1:0]       in_addr,
    input  logic [N-1:0]                 in_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [N-1:0]                 rsp_data,
    output logic                         rsp_err,
    output logic                         mc_cs,
    output logic                         mc_req,
    output logic                         mc_rw,
    output logic [$clog2(R*C)-1:0]       mc_addr,
    output logic [N-1:0]                 mc_qi,
    input  logic                         mc_ready,
    input  logic                         mc_valid,
    input  logic [N-1:0]                 mc_qa,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         busy
);
    import mem_ctrl_pkg::*;

    localparam int AW = $clog2(R * C);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int EW = 1 + AW + N;
    localparam logic [LW-1:0] LVL_ONE = LW'(1);
    localparam logic [7:0]    TMO_CNT = 8'(TMO);

    logic [EW-1:0] fifo_head;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          head_rw;
    logic [AW-1:0] head_addr;
    logic [N-1:0]  head_qi;

    sched_state_e  state_q, state_d;
    logic [7:0]    tmo_cnt_q, tmo_cnt_d;
    logic [N-1:0]  rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == ST_ISSUE) && mc_ready;
    assign {head_rw, head_addr, head_qi} = fifo_head;

    mem_req_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({in_rw, in_addr, in_wdata}),
        .pop   (pop),
        .head  (fifo_head),
        .level (level),
        .full  (fifo_full)
    );

    // Controller port is decoded from registered state and the FIFO head only
    assign mc_cs     = (state_q == ST_ISSUE) || (state_q == ST_WAIT_RD);
    assign mc_req    = (state_q == ST_ISSUE);
    assign mc_rw     = (state_q == ST_ISSUE) ? head_rw   : 1'b0;
    assign mc_addr   = (state_q == ST_ISSUE) ? head_addr : '0;
    assign mc_qi     = (state_q == ST_ISSUE) ? head_qi   : '0;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != ST_IDLE) || (level != '0);

    // Scheduler next state, read timeout counter and response capture
    always_comb begin
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (level != '0) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mc_ready) begin
                    if (head_rw == RW_READ) begin
                        state_d   = ST_WAIT_RD;
                        tmo_cnt_d = '0;
                    end else if ((level > LVL_ONE) || push) begin
                        // More work remains after this pop: issue back-to-back
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_RD: begin
                // Data arriving on the timeout cycle still counts as good data
                if (mc_valid) begin
                    rsp_data_d = mc_qa;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (tmo_cnt_q == TMO_CNT) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scheduler registers; reset abandons any in-flight request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tmo_cnt_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_cnt_q  <= tmo_cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_req_sched
// Brief   : Scoreboard bench for mem_req_sched. A host driver pushes requests
//           and predicts issue order and read responses from an abstract
//           memory model; a controller mock answers reads; monitors compare.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_req_sched;

    localparam int R = 4, C = 4, N = 4, DEPTH = 4, TMO = 15;
    localparam int AW = 4, LW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0, in_rw = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic [N-1:0]  in_wdata = '0;
    logic          in_ready, rsp_valid, rsp_err;
    logic          rsp_ready;
    logic [N-1:0]  rsp_data;
    logic          mc_cs, mc_req, mc_rw;
    logic [AW-1:0] mc_addr;
    logic [N-1:0]  mc_qi;
    logic          mc_ready, mc_valid;
    logic [N-1:0]  mc_qa;
    logic [LW-1:0] level;
    logic          busy;

    mem_req_sched #(.R(R), .C(C), .N(N), .DEPTH(DEPTH), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rw(in_rw),
        .in_addr(in_addr), .in_wdata(in_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mc_cs(mc_cs), .mc_req(mc_req), .mc_rw(mc_rw),
        .mc_addr(mc_addr), .mc_qi(mc_qi),
        .mc_ready(mc_ready), .mc_valid(mc_valid), .mc_qa(mc_qa),
        .level(level), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int rw; int addr; int data; } iss_t;
    typedef struct { int data; int err; } rsp_t;

    iss_t exp_iss[$];
    rsp_t exp_rsp[$];
    int   dly_q[$];
    int   mem_model [16];   // what memory should hold, in request order
    int   ctl_mem   [16];   // controller mock storage
    int   vec = 0, errs = 0;

    int unsigned ready_pct = 100, rsp_pct = 100;
    bit   force_stray = 0;
    bit   pending = 0, armed = 0, tmo_watch = 0, lat_chk = 0;
    int   rd_wait = 0, rd_addr = 0, tmo_k = 0, dly = 0;
    iss_t cur_iss;
    rsp_t cur_rsp;

    task automatic chk(input string name, input int act, input int exp);
        vec++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Host driver: waits for in_ready, pushes, and predicts the outcome
    task automatic push_req(input int rw, input int addr, input int wd, input int d);
        int n = 0;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("push_wait", 0, 1);
            return;
        end
        in_valid = 1'b1;
        in_rw    = (rw != 0);
        in_addr  = 4'(addr);
        in_wdata = 4'(wd);
        if (rw == 0) begin
            mem_model[addr] = wd;
            exp_iss.push_back('{0, addr, wd});
        end else begin
            exp_iss.push_back('{1, addr, 0});
            dly_q.push_back(d);
            if (d <= TMO) exp_rsp.push_back('{mem_model[addr], 0});
            else          exp_rsp.push_back('{0, 1});
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((busy || exp_rsp.size() != 0 || exp_iss.size() != 0) && n < 2000);
        if (n >= 2000) chk("idle_timeout", 0, 1);
    endtask

    function automatic int rand_dly();
        int r = int'($urandom_range(0, 9));
        if (r < 6)  return int'($urandom_range(0, 4));
        if (r < 8)  return TMO;
        if (r == 8) return TMO + 1;
        return int'($urandom_range(5, TMO - 1));
    endfunction

    // Controller mock: accepts requests, checks issue order, answers reads
    initial begin
        mc_ready = 0; mc_valid = 0; mc_qa = '0; rsp_ready = 0;
        for (int i = 0; i < 16; i++) ctl_mem[i] = 0;
        forever begin
            @(negedge clk);
            mc_valid = 1'b0;
            mc_qa    = '0;
            if (!rst) begin
                pending = 0; armed = 0; tmo_watch = 0; lat_chk = 0;
                mc_ready = 1'b0; rsp_ready = 1'b0;
            end else begin
                if (lat_chk) begin
                    chk("rd_latency", int'(rsp_valid), 1);
                    lat_chk = 0;
                end
                if (tmo_watch) begin
                    if (tmo_k == TMO) chk("tmo_early", int'(rsp_valid), 0);
                    if (tmo_k == TMO + 1) begin
                        chk("tmo_latency", int'(rsp_valid), 1);
                        tmo_watch = 0;
                    end
                    tmo_k++;
                end
                if (armed) begin
                    if (rd_wait == 0) begin
                        chk("rsp_before_valid", int'(rsp_valid), 0);
                        mc_valid = 1'b1;
                        mc_qa    = 4'(ctl_mem[rd_addr]);
                        armed    = 0;
                        lat_chk  = 1;
                    end else begin
                        rd_wait--;
                    end
                end
                rsp_ready = ($urandom_range(0, 99) < rsp_pct);
                if (rsp_valid && rsp_ready) pending = 0;
                mc_ready = ($urandom_range(0, 99) < ready_pct);
                if (mc_req && mc_ready) begin
                    if (exp_iss.size() == 0) begin
                        vec++; errs++;
                        $display("FAIL issue_unexpected: got rw=%0d addr=%0d, expected no request",
                                 mc_rw, mc_addr);
                    end else begin
                        cur_iss = exp_iss.pop_front();
                        chk("issue_cs", int'(mc_cs), 1);
                        chk("issue_rw", int'(mc_rw), cur_iss.rw);
                        chk("issue_addr", int'(mc_addr), cur_iss.addr);
                        if (cur_iss.rw == 0) chk("issue_qi", int'(mc_qi), cur_iss.data);
                    end
                    if (!mc_rw) begin
                        ctl_mem[int'(mc_addr)] = int'(mc_qi);
                    end else begin
                        dly = (dly_q.size() != 0) ? dly_q.pop_front() : TMO + 1;
                        pending = 1;
                        if (dly <= TMO) begin
                            armed = 1; rd_wait = dly; rd_addr = int'(mc_addr);
                        end else begin
                            tmo_watch = 1; tmo_k = 0;
                        end
                    end
                end
                if (force_stray || (!pending && $urandom_range(0, 7) == 0)) begin
                    mc_valid = 1'b1;
                    mc_qa    = 4'($urandom_range(0, 15));
                end
            end
        end
    end

    // Response monitor: pops expected read results on each handshake
    initial begin
        bit hold = 0;
        int prev_data = 0, prev_err = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst || !rsp_valid) begin
                hold = 0;
            end else begin
                if (hold) begin
                    chk("rsp_data_stable", int'(rsp_data), prev_data);
                    chk("rsp_err_stable", int'(rsp_err), prev_err);
                end
                if (rsp_ready) begin
                    if (exp_rsp.size() == 0) begin
                        vec++; errs++;
                        $display("FAIL rsp_unexpected: got data=%0d err=%0d, expected no response",
                                 rsp_data, rsp_err);
                    end else begin
                        cur_rsp = exp_rsp.pop_front();
                        chk("rsp_data", int'(rsp_data), cur_rsp.data);
                        chk("rsp_err", int'(rsp_err), cur_rsp.err);
                    end
                end
                hold = !rsp_ready;
                prev_data = int'(rsp_data);
                prev_err  = int'(rsp_err);
            end
        end
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed scenarios, then randomized traffic, then reset mid-operation
    initial begin
        for (int i = 0; i < 16; i++) mem_model[i] = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_level", int'(level), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_mc_cs", int'(mc_cs), 0);
        chk("rst_mc_req", int'(mc_req), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single write: two-cycle push-to-request latency, no response
        ready_pct = 100; rsp_pct = 100;
        push_req(0, 3, 1, 0);
        #1;
        chk("wr_lat_req0", int'(mc_req), 0);
        chk("wr_level1", int'(level), 1);
        @(negedge clk);
        #1;
        chk("wr_req", int'(mc_req), 1);
        chk("wr_rw", int'(mc_rw), 0);
        chk("wr_addr", int'(mc_addr), 3);
        chk("wr_qi", int'(mc_qi), 1);
        @(negedge clk);
        #1;
        chk("wr_done_req", int'(mc_req), 0);
        wait_idle();

        // Read with response held off for three cycles
        rsp_pct = 0;
        push_req(1, 3, 0, 2);
        for (int n = 0; n < 100 && !rsp_valid; n++) begin
            @(negedge clk);
            #1;
        end
        chk("rd_rsp_valid", int'(rsp_valid), 1);
        repeat (3) @(negedge clk);
        #1;
        chk("rd_hold_data", int'(rsp_data), 1);
        chk("rd_hold_err", int'(rsp_err), 0);
        rsp_pct = 100;
        wait_idle();

        // Fill the FIFO with the controller stalled; fifth push refused
        ready_pct = 0;
        for (int i = 0; i < 4; i++) push_req(0, 8 + i, 1 + i, 0);
        #1;
        chk("full_level", int'(level), 4);
        chk("full_in_ready", int'(in_ready), 0);
        in_valid = 1'b1; in_rw = 1'b0; in_addr = 4'd12; in_wdata = 4'd9;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("full_refused", int'(level), 4);
        ready_pct = 100;
        wait_idle();
        chk("drain_level", int'(level), 0);

        // Read that never returns data: timeout
        push_req(1, 5, 0, TMO + 1);
        wait_idle();

        // Write then read back-to-back, plus data arriving on the timeout cycle
        push_req(0, 5, 6, 0);
        push_req(1, 5, 0, 1);
        #1;
        chk("b2b_first_rw", int'(mc_rw), 0);
        @(negedge clk);
        #1;
        chk("b2b_second_req", int'(mc_req), 1);
        chk("b2b_second_rw", int'(mc_rw), 1);
        chk("b2b_second_addr", int'(mc_addr), 5);
        wait_idle();
        push_req(1, 5, 0, TMO);
        wait_idle();

        // Randomized traffic
        ready_pct = 60; rsp_pct = 60;
        for (int i = 0; i < 150; i++) begin
            int rw = int'($urandom_range(0, 1));
            push_req(rw, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     rw != 0 ? rand_dly() : 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();

        // Reset while a read is outstanding and two requests are queued
        ready_pct = 100; rsp_pct = 100;
        push_req(1, 7, 0, TMO + 1);
        push_req(0, 1, 2, 0);
        push_req(0, 2, 3, 0);
        #1;
        chk("mid_level", int'(level), 2);
        chk("mid_wait_cs", int'(mc_cs), 1);
        rst = 1'b0;
        #1;
        exp_iss.delete();
        exp_rsp.delete();
        dly_q.delete();
        chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_cs", int'(mc_cs), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        force_stray = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("stray_rsp_valid", int'(rsp_valid), 0);
            chk("stray_busy", int'(busy), 0);
        end
        force_stray = 0;
        repeat (3) @(negedge clk);
        chk("end_rsp_queue", exp_rsp.size(), 0);
        chk("end_iss_queue", exp_iss.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
`default_nettype wire
